// File: rtl/mult_seq_control.sv
// Control FSM for a sequential shift-add multiplier datapath.
// A CW-bit counter replaces an unrolled state chain. Each operand bit gets one
// ADD/SHIFT pair. In signed mode the final pair subtracts, which weights the
// top bit of the multiplier negatively.
module mult_seq_control #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          Check,
  input  logic          Signed,
  output logic          Clear_Ld,
  output logic          Shift,
  output logic          Add,
  output logic          Sub,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Bit_Cnt
);

  // A single-bit operand leaves no room for a separate sign iteration.
  if (WIDTH < 2) begin : g_width_chk
    $error("mult_seq_control: WIDTH must be >= 2");
  end

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          sgn_q;

  // Registered Moore flags. These are decoded from the next state, so each
  // one is valid in the same cycle as the state it describes.
  logic idle_q, clr_q, add_q, last_sub_q, shift_q, busy_q, done_q;

  assign cnt_inc = cnt + CW'(1);

  // State, counter, latched mode and registered output flags
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sgn_q      <= 1'b0;
      idle_q     <= 1'b1;
      clr_q      <= 1'b0;
      add_q      <= 1'b0;
      last_sub_q <= 1'b0;
      shift_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      clr_q      <= 1'b0;
      add_q      <= 1'b0;
      last_sub_q <= 1'b0;
      shift_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Run) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            sgn_q  <= Signed;
            idle_q <= 1'b0;
            clr_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          state      <= S_ADD;
          add_q      <= 1'b1;
          last_sub_q <= (cnt == LAST) && sgn_q;
        end
        S_ADD: begin
          state   <= S_SHIFT;
          shift_q <= 1'b1;
        end
        S_SHIFT: begin
          cnt <= cnt_inc;
          if (cnt == LAST) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state      <= S_ADD;
            add_q      <= 1'b1;
            last_sub_q <= (cnt_inc == LAST) && sgn_q;
          end
        end
        S_DONE: begin
          // Hold the result until the requester drops Run; no auto-restart.
          if (!Run) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            idle_q <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          idle_q <= 1'b1;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Only the add/sub choice and the idle clear pass-through see live inputs.
  assign Clear_Ld = idle_q ? ClearA_LoadB : clr_q;
  assign Add      = add_q & Check & ~last_sub_q;
  assign Sub      = add_q & Check &  last_sub_q;
  assign Shift    = shift_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Bit_Cnt  = cnt;

endmodule

// File: tb/tb_mult_seq_control.sv
// Bench for mult_seq_control. Two instances (WIDTH=8 and WIDTH=16) share one
// set of inputs. Checks are directed vectors, hand sequences for the
// handshake/reset corners, and random runs against a cycle-indexed model.
module tb_mult_seq_control;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Run = 1'b0, ClearA_LoadB = 1'b0, Check = 1'b0, Signed = 1'b0;

  logic cl8, sh8, ad8, sb8, bs8, dn8;
  logic [3:0] cnt8;
  logic cl16, sh16, ad16, sb16, bs16, dn16;
  logic [4:0] cnt16;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  mult_seq_control #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Check(Check), .Signed(Signed), .Clear_Ld(cl8), .Shift(sh8), .Add(ad8),
    .Sub(sb8), .Busy(bs8), .Done(dn8), .Bit_Cnt(cnt8));

  mult_seq_control #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
    .Check(Check), .Signed(Signed), .Clear_Ld(cl16), .Shift(sh16), .Add(ad16),
    .Sub(sb16), .Busy(bs16), .Done(dn16), .Bit_Cnt(cnt16));

  typedef struct {
    bit         sgn;
    logic [7:0] mult;    // Check value per ADD slot, LSB first
    bit         tog;     // flip Signed during cycle 5
    logic [7:0] add_m;   // expected Add per slot
    logic [7:0] sub_m;   // expected Sub per slot
    int         done_c;  // expected first Done cycle
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Run = 1'b0; Check = 1'b0; Signed = 1'b0; ClearA_LoadB = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  // Expected outputs in cycle c of an operation (c=1 is the CLEAR cycle),
  // derived from the cycle schedule: 1 clear, then W add/shift pairs, then done.
  function automatic void model(input int w, input int c, input bit chk_in, input bit sg,
                                output logic [5:0] o, output int cnt);
    int  s;
    bit  last;
    // o = {Clear_Ld, Shift, Add, Sub, Busy, Done}
    if (c == 1) begin
      o = 6'b100010; cnt = 0;
    end else if (c <= 2*w + 1) begin
      s = (c - 2) / 2;
      cnt = s;
      if (c % 2 == 0) begin
        last = (s == w - 1) && sg;
        o = {2'b00, chk_in && !last, chk_in && last, 2'b10};
      end else begin
        o = 6'b010010;
      end
    end else begin
      o = 6'b000001; cnt = w;
    end
  endfunction

  task automatic run_vec(input int idx);
    vec_t v;
    logic [7:0] am, sm, shm;
    int na, ns, nsh, dc, s;
    logic cl1;
    v = tbl[idx];
    am = '0; sm = '0; shm = '0; na = 0; ns = 0; nsh = 0; dc = -1; cl1 = 1'b0;
    do_reset();
    Signed = v.sgn; Run = 1'b1;
    tick();
    for (int c = 1; c <= 24; c++) begin
      s = (c < 2) ? 0 : (((c - 2) / 2 > 7) ? 7 : (c - 2) / 2);
      Check = (c >= 2) ? v.mult[s] : 1'b0;
      if (v.tog && c == 5) Signed = ~v.sgn;
      #1;
      if (c == 1) cl1 = cl8;
      if (c >= 2 && c <= 16 && c % 2 == 0) begin am[s] = ad8; sm[s] = sb8; end
      if (c >= 3 && c <= 17 && c % 2 == 1) shm[s] = sh8;
      na += int'(ad8); ns += int'(sb8); nsh += int'(sh8);
      if (dn8 && dc < 0) dc = c;
      tick();
    end
    chk($sformatf("v%0d_clear_c1", idx), cl1, 1);
    chk($sformatf("v%0d_add_mask", idx), am, v.add_m);
    chk($sformatf("v%0d_sub_mask", idx), sm, v.sub_m);
    chk($sformatf("v%0d_shift_mask", idx), shm, 8'hFF);
    chk($sformatf("v%0d_n_add", idx), na, $countones(v.add_m));
    chk($sformatf("v%0d_n_sub", idx), ns, $countones(v.sub_m));
    chk($sformatf("v%0d_n_shift", idx), nsh, 8);
    chk($sformatf("v%0d_done_cyc", idx), dc, v.done_c);
    #1;
    chk($sformatf("v%0d_bitcnt", idx), cnt8, 8);
  endtask

  initial begin
    logic [5:0] e;
    int ec, dc;
    bit sg0;

    tbl[0] = '{1'b1, 8'hFF, 1'b0, 8'h7F, 8'h80, 18};
    tbl[1] = '{1'b0, 8'hFF, 1'b1, 8'hFF, 8'h00, 18};
    tbl[2] = '{1'b1, 8'hA5, 1'b0, 8'h25, 8'h80, 18};
    tbl[3] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 8'h00, 18};
    tbl[4] = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 18};
    tbl[5] = '{1'b1, 8'h80, 1'b0, 8'h00, 8'h80, 18};

    // Reset state: everything low except Clear_Ld tracking ClearA_LoadB
    @(negedge Clk);
    Reset = 1'b1; ClearA_LoadB = 1'b1;
    #1;
    chk("rst_outs8", {cl8, sh8, ad8, sb8, bs8, dn8}, 6'b100000);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_outs16", {cl16, sh16, ad16, sb16, bs16, dn16}, 6'b100000);
    ClearA_LoadB = 1'b0;
    #1;
    chk("rst_clr_follow", cl8, 0);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Completion handshake
    do_reset();
    Signed = 1'b1; Check = 1'b1; Run = 1'b1;
    tick();
    repeat (17) tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hs_done_hold", {cl8, sh8, ad8, sb8, bs8, dn8}, 6'b000001);
      tick();
    end
    Run = 1'b0;
    tick(); #1;
    chk("hs_idle", {bs8, dn8}, 0);
    chk("hs_idle_cnt", cnt8, 8);
    tick(); #1;
    chk("hs_no_restart", {cl8, sh8, ad8, sb8, bs8, dn8}, 0);
    Run = 1'b1;
    tick(); #1;
    chk("hs_restart", {cl8, bs8}, 2'b11);
    chk("hs_restart_cnt", cnt8, 0);

    // Async reset mid-SHIFT at cnt=3 (cycle 9)
    do_reset();
    Check = 1'b1; Run = 1'b1;
    tick();
    repeat (8) tick();
    #1;
    chk("ar_pre_shift", sh8, 1);
    chk("ar_pre_cnt", cnt8, 3);
    Run = 1'b0;
    Reset = 1'b1;
    #1;
    chk("ar_busy_shift", {bs8, sh8, dn8}, 0);
    chk("ar_cnt", cnt8, 0);
    Reset = 1'b0;

    // WIDTH=16 idle clear handshake and full run
    do_reset();
    ClearA_LoadB = 1'b1;
    #1;
    chk("w16_idle_clr", cl16, 1);
    ClearA_LoadB = 1'b0;
    #1;
    chk("w16_idle_clr_off", cl16, 0);
    Run = 1'b1; Signed = 1'($urandom); Check = 1'b1;
    tick();
    tick();
    ClearA_LoadB = 1'b1;
    #1;
    chk("w16_add_clr_ignored", cl16, 0);
    ClearA_LoadB = 1'b0;
    dc = -1;
    for (int c = 2; c <= 60; c++) begin
      #1;
      if (dn16) begin dc = c; break; end
      tick();
    end
    chk("w16_done_cyc", dc, 34);
    chk("w16_bitcnt", cnt16, 16);

    // Randomized runs against the model, both widths concurrently
    for (int it = 0; it < 8; it++) begin
      do_reset();
      Signed = 1'($urandom); sg0 = Signed; Run = 1'b1;
      tick();
      for (int c = 1; c <= 40; c++) begin
        Check = 1'($urandom);
        Signed = 1'($urandom);
        ClearA_LoadB = 1'($urandom);
        Run = (c < 17) ? 1'($urandom) : 1'b1;
        #1;
        model(8, c, Check, sg0, e, ec);
        chk($sformatf("rnd%0d_c%0d_o8", it, c), {cl8, sh8, ad8, sb8, bs8, dn8}, e);
        chk($sformatf("rnd%0d_c%0d_n8", it, c), cnt8, ec);
        model(16, c, Check, sg0, e, ec);
        chk($sformatf("rnd%0d_c%0d_o16", it, c), {cl16, sh16, ad16, sb16, bs16, dn16}, e);
        chk($sformatf("rnd%0d_c%0d_n16", it, c), cnt16, ec);
        tick();
      end
      Run = 1'b0;
      tick();
      ClearA_LoadB = 1'($urandom);
      #1;
      chk($sformatf("rnd%0d_idle8", it), {cl8, sh8, ad8, sb8, bs8, dn8}, {ClearA_LoadB, 5'b0});
      chk($sformatf("rnd%0d_idle_n8", it), cnt8, 8);
      chk($sformatf("rnd%0d_idle16", it), {cl16, sh16, ad16, sb16, bs16, dn16}, {ClearA_LoadB, 5'b0});
      chk($sformatf("rnd%0d_idle_n16", it), cnt16, 16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
